// File: rtl/seg_pkg.sv
// Shared types and seven-segment code table
// for the multiplexed hex display scheduler.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // {g,f,e,d,c,b,a}, active high, digits 0..F
  localparam logic [6:0] SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to
// seven-segment pattern lookup.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup, no state
  always_comb begin
    seg = SEG7[hex];
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Round-robin digit scanner with blanking
// gaps and frame-synchronous buffer commit.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 1000,
  parameter  int BLANK_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IW-1:0]         wr_idx,
  input  logic [3:0]            wr_data,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_start
);

  localparam int CMAX =
    (DWELL_CYCLES > BLANK_CYCLES) ?
    DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST =
    CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fs_q, fs_d;
  logic                    rdy_q;
  logic                    dirty_q, dirty_d;
  logic [3:0]              active_q [NUM_DIGITS];
  logic [3:0]              active_d [NUM_DIGITS];
  logic [3:0]              shadow_q [NUM_DIGITS];
  logic [3:0]              shadow_d [NUM_DIGITS];

  logic                    last_show;
  logic                    commit;
  logic                    wr_fire;
  logic                    wr_hit;
  logic [6:0]              dec_seg;

  // Final SHOW cycle of the last digit is the frame boundary
  always_comb begin
    last_show = (state_q == SHOW) &&
                (idx_q == IDX_LAST) &&
                (cnt_q == DWELL_LAST);
    commit    = last_show && ena && dirty_q;
    wr_ready  = rdy_q && !(last_show && dirty_q);
    wr_fire   = wr_valid && wr_ready;
    wr_hit    = wr_fire &&
                (int'(wr_idx) < NUM_DIGITS);
  end

  // Decode the digit that will be driven next cycle
  seg7_hex_decode u_dec (
    .hex (active_q[idx_d]),
    .seg (dec_seg)
  );

  // Scan FSM: next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          fs_d    = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              fs_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
    if (state_d == SHOW) begin
      sel_d = NUM_DIGITS'(1) << idx_d;
      seg_d = dec_seg;
    end else begin
      sel_d = '0;
      seg_d = SEG_BLANK;
    end
  end

  // Shadow/active buffers, commit at frame end
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    if (commit) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
    end
    if (wr_hit) begin
      shadow_d[wr_idx] = wr_data;
      if (state_q == IDLE) begin
        active_d[wr_idx] = wr_data;
      end else begin
        dirty_d = 1'b1;
      end
    end
  end

  // State, counters, outputs and buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      sel_q    <= '0;
      fs_q     <= 1'b0;
      rdy_q    <= 1'b0;
      dirty_q  <= 1'b0;
      active_q <= '{default: '0};
      shadow_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      fs_q     <= fs_d;
      rdy_q    <= 1'b1;
      dirty_q  <= dirty_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  assign seg_out     = seg_q;
  assign dig_sel     = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Randomized bench for seg_scan_scheduler
// against a frame-position reference model.
module tb_seg_scan_scheduler;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int SLOT = BL + DW;
  localparam int FP = ND * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic [6:0] seg_out;
  logic [3:0] dig_sel;
  logic       frame_start;

  always #5 clk = ~clk;

  seg_scan_scheduler #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .seg_out     (seg_out),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] ref_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [3:0] m_active [ND];
  logic [3:0] m_shadow [ND];
  bit         m_dirty;
  bit         m_run;
  bit         m_rdy;
  int         m_t;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
    m_dirty = 0;
    m_run   = 0;
    m_rdy   = 0;
    m_t     = 0;
  endtask

  function automatic bit exp_ready();
    return m_rdy &&
      !(m_run && (m_t % FP) == FP - 1 && m_dirty);
  endfunction

  task automatic model_step();
    bit acc;
    if (!rst_n) return;
    acc = wr_valid && exp_ready();
    m_rdy = 1;
    if (!m_run) begin
      if (acc) begin
        m_shadow[wr_idx] = wr_data;
        m_active[wr_idx] = wr_data;
      end
      if (ena) begin
        m_run = 1;
        m_t   = 0;
      end
    end else if (!ena) begin
      m_run = 0;
      if (acc) begin
        m_shadow[wr_idx] = wr_data;
        m_dirty = 1;
      end
    end else begin
      if ((m_t % FP) == FP - 1 && m_dirty) begin
        for (int i = 0; i < ND; i++)
          m_active[i] = m_shadow[i];
        m_dirty = 0;
      end
      if (acc) begin
        m_shadow[wr_idx] = wr_data;
        m_dirty = 1;
      end
      m_t++;
    end
  endtask

  function automatic bit in_show();
    return m_run && ((m_t % FP) % SLOT) >= BL;
  endfunction

  task automatic do_checks();
    int pos, d, w;
    logic [6:0] es;
    logic [3:0] ed;
    logic       ef;
    es = '0;
    ed = '0;
    ef = 1'b0;
    if (m_run) begin
      pos = m_t % FP;
      d   = pos / SLOT;
      w   = pos % SLOT;
      ef  = (pos == 0);
      if (w >= BL) begin
        ed = 4'(1 << d);
        es = ref_tbl[m_active[d]];
      end
    end
    check("seg_out", 32'(seg_out), 32'(es));
    check("dig_sel", 32'(dig_sel), 32'(ed));
    check("frame_start", 32'(frame_start), 32'(ef));
    check("wr_ready", 32'(wr_ready), 32'(exp_ready()));
  endtask

  initial begin
    bit rst_done;
    int rel_at;
    rst_done = 0;
    rel_at   = -1;
    rst_n    = 1'b0;
    ena      = 1'b1;
    wr_valid = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    do_checks();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      do_checks();
      if (!rst_done && cyc >= 1500 &&
          ((in_show() && m_dirty) || cyc >= 2000)) begin
        rst_done = 1;
        rst_n    = 1'b0;
        #1;
        check("async_seg", 32'(seg_out), 32'd0);
        check("async_sel", 32'(dig_sel), 32'd0);
        check("async_fs", 32'(frame_start), 32'd0);
        check("async_rdy", 32'(wr_ready), 32'd0);
        model_reset();
        rel_at = cyc + 4;
      end else if (cyc == rel_at) begin
        rst_n = 1'b1;
      end
      if (cyc < 20) begin
        ena      = 1'b0;
        wr_valid = 1'b1;
      end else begin
        if (ena)
          ena = ($urandom_range(0, 299) != 0);
        else
          ena = ($urandom_range(0, 3) == 0);
        if (cyc >= 800 && cyc < 900)
          wr_valid = 1'b1;
        else
          wr_valid = ($urandom_range(0, 7) == 0);
      end
      wr_idx  = 2'($urandom);
      wr_data = 4'($urandom);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
